// File: rtl/lexpander_pkg.sv
// Shared types and constants for the downward expander / noise gate.
package lexpander_pkg;

  localparam int Q_W_TOTAL = 16;
  localparam int Q_W_GAIN  = 16;
  localparam int Q_W_HOLD  = 16;

  localparam logic [Q_W_GAIN-1:0]         UNITY   = 16'h8000;
  localparam logic signed [Q_W_TOTAL-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [Q_W_TOTAL-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    ATTACK  = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } gate_state_t;

endpackage

// File: rtl/lexpander_gate_mul.sv
// Output stage: signed sample times unsigned Q1.15 gain, floor-rounded shift, saturation.
module gain_mul_sat #(
  parameter int W_TOTAL = 16,
  parameter int W_GAIN  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      valid,
  input  logic signed [W_TOTAL-1:0] data,
  input  logic [W_GAIN-1:0]         gain,
  output logic signed [W_TOTAL-1:0] result,
  output logic                      result_valid
);

  localparam int W_PROD = W_TOTAL + W_GAIN + 1;

  logic signed [W_PROD-1:0]  data_ext;
  logic signed [W_PROD-1:0]  gain_ext;
  logic signed [W_PROD-1:0]  product;
  logic signed [W_PROD-1:0]  shifted;
  logic                      fits;
  logic signed [W_TOTAL-1:0] sat_val;

  // Full-width product, arithmetic shift back to Q1.15, clamp when the upper bits are not pure sign.
  always_comb begin
    data_ext = W_PROD'(data);
    gain_ext = $signed(W_PROD'({1'b0, gain}));
    product  = data_ext * gain_ext;
    shifted  = product >>> (W_GAIN - 1);
    fits     = (shifted[W_PROD-1:W_TOTAL-1] == {(W_PROD-W_TOTAL+1){shifted[W_PROD-1]}});
    if (fits) begin
      sat_val = shifted[W_TOTAL-1:0];
    end else if (shifted[W_PROD-1]) begin
      sat_val = {1'b1, {(W_TOTAL-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(W_TOTAL-1){1'b1}}};
    end
  end

  // Register the result only for valid samples; the valid bit itself always shifts through.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= valid;
      if (valid) begin
        result <= sat_val;
      end
    end
  end

endmodule

// File: rtl/lexpander_gate.sv
// Downward expander / noise gate: gain FSM ramping between floor and unity, plus a 2-stage output pipe.
module lexpander_gate
  import lexpander_pkg::*;
#(
  parameter int W_TOTAL = Q_W_TOTAL,
  parameter int W_GAIN  = Q_W_GAIN,
  parameter int W_HOLD  = Q_W_HOLD
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_ce,
  input  logic signed [W_TOTAL-1:0] i_data,
  input  logic [W_TOTAL-1:0]        i_threshold,
  input  logic [W_GAIN-1:0]         i_floor_gain,
  input  logic [W_GAIN-1:0]         i_attack_step,
  input  logic [W_GAIN-1:0]         i_release_step,
  input  logic [W_HOLD-1:0]         i_hold_samples,
  output logic signed [W_TOTAL-1:0] o_data,
  output logic                      o_ce,
  output logic                      o_gate_open,
  output logic [W_GAIN-1:0]         o_gain
);

  localparam logic [W_GAIN-1:0]  unity_gain = {1'b1, {(W_GAIN-1){1'b0}}};
  localparam logic [W_TOTAL-1:0] most_neg   = {1'b1, {(W_TOTAL-1){1'b0}}};
  localparam logic [W_TOTAL-1:0] most_pos   = {1'b0, {(W_TOTAL-1){1'b1}}};

  gate_state_t              state, state_n;
  logic [W_GAIN-1:0]        gain, gain_n;
  logic [W_HOLD-1:0]        hold_cnt, hold_n;
  logic                     gate_open;
  logic signed [W_TOTAL-1:0] d1;
  logic [W_GAIN-1:0]        g1;
  logic                     v1;

  logic [W_TOTAL-1:0] mag;
  logic               above;
  logic [W_GAIN-1:0]  floor_c;
  logic [W_GAIN:0]    up_sum;
  logic [W_GAIN:0]    dn_diff;
  logic [W_GAIN-1:0]  up_gain;
  logic [W_GAIN-1:0]  dn_gain;
  logic               up_done;
  logic               dn_done;

  // Sample magnitude (most negative value saturates), clamped floor and both ramp candidates.
  always_comb begin
    if (!i_data[W_TOTAL-1]) begin
      mag = i_data;
    end else if (i_data == most_neg) begin
      mag = most_pos;
    end else begin
      mag = -i_data;
    end
    above   = (mag >= i_threshold);
    floor_c = (i_floor_gain > unity_gain) ? unity_gain : i_floor_gain;
    up_sum  = {1'b0, gain} + {1'b0, i_attack_step};
    dn_diff = {1'b0, gain} - {1'b0, i_release_step};
    if ((i_attack_step == '0) || (up_sum >= {1'b0, unity_gain})) begin
      up_gain = unity_gain;
    end else begin
      up_gain = up_sum[W_GAIN-1:0];
    end
    if ((i_release_step == '0) || dn_diff[W_GAIN] || (dn_diff[W_GAIN-1:0] <= floor_c)) begin
      dn_gain = floor_c;
    end else begin
      dn_gain = dn_diff[W_GAIN-1:0];
    end
    up_done = (up_gain == unity_gain);
    dn_done = (dn_gain == floor_c);
  end

  // Next-state and gain ramp, advancing only on accepted samples.
  always_comb begin
    state_n = state;
    gain_n  = gain;
    hold_n  = hold_cnt;
    if (i_ce) begin
      case (state)
        CLOSED: begin
          if (above) begin
            gain_n  = up_gain;
            state_n = up_done ? OPEN : ATTACK;
          end else begin
            gain_n = floor_c;
          end
        end
        ATTACK: begin
          gain_n = up_gain;
          if (up_done) begin
            state_n = OPEN;
          end
        end
        OPEN: begin
          gain_n = unity_gain;
          hold_n = '0;
          if (!above) begin
            if (i_hold_samples == '0) begin
              gain_n  = dn_gain;
              state_n = dn_done ? CLOSED : RELEASE;
            end else begin
              state_n = HOLD;
              hold_n  = W_HOLD'(1);
            end
          end
        end
        HOLD: begin
          if (above) begin
            state_n = OPEN;
            gain_n  = unity_gain;
            hold_n  = '0;
          end else if (hold_cnt >= i_hold_samples) begin
            gain_n  = dn_gain;
            state_n = dn_done ? CLOSED : RELEASE;
            hold_n  = '0;
          end else begin
            hold_n = hold_cnt + W_HOLD'(1);
          end
        end
        RELEASE: begin
          if (above) begin
            gain_n  = up_gain;
            state_n = up_done ? OPEN : ATTACK;
          end else begin
            gain_n = dn_gain;
            if (dn_done) begin
              state_n = CLOSED;
            end
          end
        end
        default: begin
          state_n = CLOSED;
          gain_n  = floor_c;
          hold_n  = '0;
        end
      endcase
    end
  end

  // FSM registers, gate flag and stage-1 capture of the sample with its own updated gain.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state     <= CLOSED;
      gain      <= '0;
      hold_cnt  <= '0;
      gate_open <= 1'b0;
      d1        <= '0;
      g1        <= '0;
      v1        <= 1'b0;
    end else begin
      state     <= state_n;
      gain      <= gain_n;
      hold_cnt  <= hold_n;
      gate_open <= (state_n == ATTACK) || (state_n == OPEN) || (state_n == HOLD);
      v1        <= i_ce;
      if (i_ce) begin
        d1 <= i_data;
        g1 <= gain_n;
      end
    end
  end

  gain_mul_sat #(
    .W_TOTAL(W_TOTAL),
    .W_GAIN (W_GAIN)
  ) u_mul (
    .clk         (i_clk),
    .reset_n     (i_reset_n),
    .valid       (v1),
    .data        (d1),
    .gain        (g1),
    .result      (o_data),
    .result_valid(o_ce)
  );

  assign o_gain      = gain;
  assign o_gate_open = gate_open;

endmodule

// File: tb/tb_lexpander_gate.sv
// Directed bench for lexpander_gate: vector table for the main gain trajectory plus corner sequences.
module tb_lexpander_gate;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce;
  logic [15:0] data;
  logic [15:0] thr;
  logic [15:0] floor_g;
  logic [15:0] att;
  logic [15:0] rel;
  logic [15:0] hold;
  logic [15:0] out_data;
  logic        out_ce;
  logic        gate;
  logic [15:0] gain;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        ce;
    logic [15:0] data;
    logic [15:0] exp_gain;
    logic        exp_gate;
    logic [15:0] exp_out;
    logic        exp_oce;
  } vec_t;

  vec_t vecs[$];

  lexpander_gate dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_ce          (ce),
    .i_data        (data),
    .i_threshold   (thr),
    .i_floor_gain  (floor_g),
    .i_attack_step (att),
    .i_release_step(rel),
    .i_hold_samples(hold),
    .o_data        (out_data),
    .o_ce          (out_ce),
    .o_gate_open   (gate),
    .o_gain        (gain)
  );

  always #5 clk = ~clk;

  task automatic add_vec(input logic c, input logic [15:0] d, input logic [15:0] g,
                         input logic gt, input logic [15:0] o, input logic oc);
    vec_t v;
    v.ce = c; v.data = d; v.exp_gain = g; v.exp_gate = gt; v.exp_out = o; v.exp_oce = oc;
    vecs.push_back(v);
  endtask

  task automatic set_cfg(input logic [15:0] t, input logic [15:0] f, input logic [15:0] a,
                         input logic [15:0] r, input logic [15:0] h);
    thr = t; floor_g = f; att = a; rel = r; hold = h;
  endtask

  task automatic apply_stimulus(input logic rst_n, input logic c, input logic [15:0] d);
    reset_n = rst_n;
    ce      = c;
    data    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [15:0] g, input logic gt,
                           input logic [15:0] o, input logic oc);
    check_output({name, " gain"}, gain, g);
    check_output({name, " gate"}, {15'd0, gate}, {15'd0, gt});
    check_output({name, " data"}, out_data, o);
    check_output({name, " o_ce"}, {15'd0, out_ce}, {15'd0, oc});
  endtask

  initial begin
    reset_n = 1'b0;
    ce      = 1'b0;
    data    = '0;
    set_cfg(16'h1000, 16'h0000, 16'h2000, 16'h1000, 16'd3);

    // Quiet below-threshold input, then attack, hold, release, retrigger and ce gaps.
    for (int r = 0; r < 10; r++) add_vec(1, 16'h0800, 16'h0000, 0, 16'h0000, (r != 0));
    add_vec(1, 16'h4000, 16'h2000, 1, 16'h0000, 1);
    add_vec(1, 16'h4000, 16'h4000, 1, 16'h1000, 1);
    add_vec(1, 16'h4000, 16'h6000, 1, 16'h2000, 1);
    add_vec(1, 16'h4000, 16'h8000, 1, 16'h3000, 1);
    add_vec(1, 16'h4000, 16'h8000, 1, 16'h4000, 1);
    add_vec(1, 16'h4000, 16'h8000, 1, 16'h4000, 1);
    add_vec(1, 16'h0800, 16'h8000, 1, 16'h4000, 1);
    add_vec(1, 16'h0800, 16'h8000, 1, 16'h0800, 1);
    add_vec(1, 16'h0800, 16'h8000, 1, 16'h0800, 1);
    add_vec(1, 16'h0800, 16'h7000, 0, 16'h0800, 1);
    add_vec(1, 16'h0800, 16'h6000, 0, 16'h0700, 1);
    add_vec(1, 16'h0800, 16'h5000, 0, 16'h0600, 1);
    add_vec(1, 16'h0800, 16'h4000, 0, 16'h0500, 1);
    add_vec(1, 16'h0800, 16'h3000, 0, 16'h0400, 1);
    add_vec(1, 16'h0800, 16'h2000, 0, 16'h0300, 1);
    add_vec(1, 16'h0800, 16'h1000, 0, 16'h0200, 1);
    add_vec(1, 16'h0800, 16'h0000, 0, 16'h0100, 1);
    add_vec(1, 16'h0800, 16'h0000, 0, 16'h0000, 1);
    add_vec(1, 16'h4000, 16'h2000, 1, 16'h0000, 1);
    add_vec(1, 16'h4000, 16'h4000, 1, 16'h1000, 1);
    add_vec(1, 16'h4000, 16'h6000, 1, 16'h2000, 1);
    add_vec(1, 16'h4000, 16'h8000, 1, 16'h3000, 1);
    add_vec(1, 16'h0800, 16'h8000, 1, 16'h4000, 1);
    add_vec(1, 16'h0800, 16'h8000, 1, 16'h0800, 1);
    add_vec(1, 16'h0800, 16'h8000, 1, 16'h0800, 1);
    add_vec(1, 16'h0800, 16'h7000, 0, 16'h0800, 1);
    add_vec(1, 16'h0800, 16'h6000, 0, 16'h0700, 1);
    add_vec(1, 16'h0800, 16'h5000, 0, 16'h0600, 1);
    add_vec(1, 16'h2000, 16'h7000, 1, 16'h0500, 1);
    add_vec(1, 16'h2000, 16'h8000, 1, 16'h1C00, 1);
    add_vec(1, 16'h2000, 16'h8000, 1, 16'h2000, 1);
    add_vec(0, 16'h0100, 16'h8000, 1, 16'h2000, 1);
    add_vec(0, 16'h0100, 16'h8000, 1, 16'h2000, 0);
    add_vec(1, 16'h0100, 16'h8000, 1, 16'h2000, 0);
    add_vec(0, 16'h0100, 16'h8000, 1, 16'h0100, 1);

    apply_stimulus(0, 0, 16'h0000);
    apply_stimulus(0, 0, 16'h0000);
    check_all("reset", 16'h0000, 0, 16'h0000, 0);

    foreach (vecs[i]) begin
      apply_stimulus(1, vecs[i].ce, vecs[i].data);
      check_all($sformatf("vec%0d", i), vecs[i].exp_gain, vecs[i].exp_gate,
                vecs[i].exp_out, vecs[i].exp_oce);
    end

    // Most negative input at unity with instant attack and maximum threshold.
    set_cfg(16'h7FFF, 16'h0000, 16'h0000, 16'h1000, 16'd3);
    apply_stimulus(0, 0, 16'h0000);
    apply_stimulus(1, 1, 16'h8000);
    check_output("minneg gain", gain, 16'h8000);
    check_output("minneg gate", {15'd0, gate}, 16'h0001);
    apply_stimulus(1, 1, 16'h8000);
    check_output("minneg data", out_data, 16'h8000);

    // Negative one at half gain rounds toward minus infinity.
    set_cfg(16'h1000, 16'h4000, 16'h2000, 16'h1000, 16'd3);
    apply_stimulus(0, 0, 16'h0000);
    apply_stimulus(1, 1, 16'hFFFF);
    check_output("round gain", gain, 16'h4000);
    apply_stimulus(1, 0, 16'hFFFF);
    check_output("round data", out_data, 16'hFFFF);

    // Floor above unity is clamped.
    set_cfg(16'h1000, 16'h9000, 16'h2000, 16'h1000, 16'd3);
    apply_stimulus(0, 0, 16'h0000);
    apply_stimulus(1, 1, 16'h0000);
    check_output("floorclamp gain", gain, 16'h8000);
    check_output("floorclamp gate", {15'd0, gate}, 16'h0000);

    // Sparse strobes with a reset pulse in the middle of an attack ramp.
    set_cfg(16'h1000, 16'h0000, 16'h2000, 16'h1000, 16'd3);
    apply_stimulus(0, 0, 16'h0000);
    apply_stimulus(1, 1, 16'h4000);
    check_all("sparse0", 16'h2000, 1, 16'h0000, 0);
    apply_stimulus(1, 0, 16'h4000);
    check_all("sparse1", 16'h2000, 1, 16'h1000, 1);
    apply_stimulus(1, 0, 16'h4000);
    check_all("sparse2", 16'h2000, 1, 16'h1000, 0);
    apply_stimulus(1, 0, 16'h4000);
    check_output("sparse3 gain", gain, 16'h2000);
    apply_stimulus(1, 1, 16'h4000);
    check_output("sparse4 gain", gain, 16'h4000);
    apply_stimulus(1, 0, 16'h4000);
    check_all("sparse5", 16'h4000, 1, 16'h2000, 1);
    apply_stimulus(0, 1, 16'h4000);
    check_all("midreset", 16'h0000, 0, 16'h0000, 0);
    apply_stimulus(1, 1, 16'h0800);
    check_all("resume0", 16'h0000, 0, 16'h0000, 0);
    apply_stimulus(1, 0, 16'h0800);
    check_all("resume1", 16'h0000, 0, 16'h0000, 1);
    apply_stimulus(1, 0, 16'h0800);
    apply_stimulus(1, 0, 16'h0800);
    apply_stimulus(1, 1, 16'h4000);
    check_output("resume2 gain", gain, 16'h2000);
    check_output("resume2 gate", {15'd0, gate}, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
